ex_issue_ctrl: RTL and testbench
================================

Name: ex_issue_ctrl

Overview:
Sequencing controller for the execute stage's combinational ALU/branch unit. It accepts one decoded instruction at a time from ID/EX and holds issue while a multi-cycle multiply completes. It tells the EX/MEM register when to capture the ALU result, and flushes younger instructions on a taken branch. It sits between the ID/EX pipeline register and the EX/MEM register.

Parameters:
MUL_LATENCY, 4, cycles a multiply (opcode 0, alu_control 3) occupies the ALU; legal range 2..16.
FLUSH_CYCLES, 2, cycles flush is held after a taken branch; legal range 1..4.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ID/EX holds a valid instruction
in_ready  output  1  controller accepts the instruction this cycle
opcode  input  6  instruction opcode from ID/EX
alu_control  input  6  R-type function select from ID/EX
branch_taken  input  1  branch compare result from execution unit; meaningful only in accept cycle of opcode 3
ex_latch  output  1  one-cycle pulse: EX/MEM captures ALU result this cycle
out_valid  output  1  EX/MEM holds a completed result
out_ready  input  1  MEM stage consumes result
flush  output  1  squash IF/ID and ID/EX contents
mul_busy  output  1  multiply in progress
illegal  output  1  one-cycle pulse: unsupported opcode/function accepted and dropped

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low. While rst_n=0: state=IDLE, counters=0, every output 0 (in_ready forced 0). All outputs follow state/registers only after rst_n deasserts. Reset mid-multiply or mid-flush abandons the operation; no ex_latch or out_valid follows.
- Legal set: opcode 0 with alu_control 1..4; opcodes 1, 2, 3, 8. Anything else is illegal.
- Accept = in_valid & in_ready.
- States: IDLE, MUL, DONE, FLUSH.
- in_ready = 1 in IDLE; 1 in DONE when out_ready=1; 0 in MUL and FLUSH.
- IDLE / DONE-with-handoff, on accept:
  - illegal: pulse illegal; go to IDLE; no ex_latch.
  - multiply: go to MUL; counter loads MUL_LATENCY-1; mul_busy=1 from next cycle.
  - opcode 3: ex_latch=1 same cycle; register branch_taken into take_q; go to DONE.
  - other legal op: ex_latch=1 same cycle; go to DONE.
- Single-cycle latency: accept cycle to out_valid is 1 cycle.
- MUL:
  - counter decrements each cycle; mul_busy=1.
  - When counter==1: ex_latch=1 and go to DONE. Total MUL_LATENCY cycles from accept to out_valid.
  - in_valid is ignored and upstream holds.
- DONE:
  - out_valid=1 until out_ready=1.
  - On out_ready with take_q=1: go to FLUSH with flush counter=FLUSH_CYCLES; in_ready=0 that cycle.
  - Else on out_ready: a same-cycle accept is processed as in IDLE (back-to-back issue); with no accept, go to IDLE.
  - out_ready=0: hold state and out_valid; no ex_latch.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles, then go to IDLE.
  - take_q clears on FLUSH entry.
  - in_valid during FLUSH is never accepted.
- Simultaneous events: out_ready and an illegal in_valid in DONE gives out_valid drop plus an illegal pulse, then IDLE. branch_taken outside an opcode-3 accept cycle is ignored.
- Width rules:
  - MUL counter is $clog2(MUL_LATENCY+1) bits, unsigned, never wraps below 0.
  - Flush counter is 3 bits.

Decomposition:
- Shared package ex_ctrl_pkg holds:
  - Opcode constants: OP_RTYPE=0, OP_ADDI=1, OP_LW=2, OP_BEQ=3, OP_SW=8.
  - Function constants: FN_ADD=1, FN_SUB=2, FN_MUL=3, FN_AND=4.
  - 2-bit state typedef {IDLE, MUL, DONE, FLUSH}.
  - Function is_legal(opcode, alu_control).
- One sub-module is natural: ex_cycle_timer, a loadable down-counter with a done flag (generic width). It is instantiated once for the multiply counter and once for the flush counter.

Test Plan:
- Reset: hold rst_n=0 3 cycles with in_valid=1, opcode=1 -> all outputs 0; after release, in_ready=1 and no ex_latch until an accept.
- Add: opcode 0, alu_control 1, in_valid 1 cycle, out_ready=1 -> ex_latch in cycle 0, out_valid cycle 1 only, state back to IDLE cycle 2.
- Multiply: opcode 0, alu_control 3, MUL_LATENCY=4 -> mul_busy cycles 1-3, ex_latch cycle 3, out_valid cycle 4; in_ready=0 cycles 1-4 with in_valid held high.
- Taken branch: opcode 3, branch_taken=1, out_ready=1 -> out_valid cycle 1, flush=1 cycles 2-3 (FLUSH_CYCLES=2), in_ready=1 again cycle 4. Repeat with branch_taken=0 -> no flush.
- Backpressure and back-to-back issue: two addi with out_ready=0 for 3 cycles -> out_valid held, second not accepted; raising out_ready gives handoff plus accept in the same cycle and a second ex_latch.
- Illegal and async reset: opcode 5 -> single illegal pulse, no out_valid. Multiply with rst_n pulsed low mid-MUL -> outputs 0 immediately, no later ex_latch.

Source files
------------

// File: rtl/ex_ctrl_pkg.sv
// Shared definitions for the execute-stage issue controller.
//   - opcode / ALU function constants
//   - FSM state type
//   - is_legal(): the instruction set this execute stage supports
package ex_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_LW    = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd3;
    localparam logic [5:0] OP_SW    = 6'd8;

    localparam logic [5:0] FN_ADD = 6'd1;
    localparam logic [5:0] FN_SUB = 6'd2;
    localparam logic [5:0] FN_MUL = 6'd3;
    localparam logic [5:0] FN_AND = 6'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DONE  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] alu_control);
        logic ok;
        ok = 1'b0;
        case (opcode)
            OP_RTYPE: ok = (alu_control == FN_ADD) || (alu_control == FN_SUB) ||
                           (alu_control == FN_MUL) || (alu_control == FN_AND);
            OP_ADDI, OP_LW, OP_BEQ, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ex_cycle_timer.sv
// Loadable down-counter with terminal-count flag.
//   clk, rst_n   : clock, async active-low reset
//   load_i       : load load_val_i (wins over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement by one; saturates at zero
//   done_o       : count is 1, i.e. this is the final counted cycle
module ex_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == W'(1));

endmodule

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller: accepts one decoded instruction at a time,
// stalls issue during multi-cycle multiplies, strobes the EX/MEM capture and
// flushes younger instructions after a taken branch hands off.
//   in_valid_i/in_ready_o   : ID/EX handshake
//   opcode_i, alu_control_i : decoded instruction
//   branch_taken_i          : branch compare, sampled on an opcode-3 accept
//   ex_latch_o              : EX/MEM capture strobe
//   out_valid_o/out_ready_i : EX/MEM to MEM handshake
//   flush_o                 : squash IF/ID and ID/EX
//   mul_busy_o              : multiply in progress
//   illegal_o               : unsupported instruction accepted and dropped
//
// state | meaning
// IDLE  | empty, ready to accept
// MUL   | multiply occupying the ALU, issue stalled
// DONE  | EX/MEM holds a result waiting for MEM
// FLUSH | squashing younger instructions after a taken branch
module ex_issue_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY  = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [5:0] opcode_i,
    input  logic [5:0] alu_control_i,
    input  logic       branch_taken_i,
    output logic       ex_latch_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       flush_o,
    output logic       mul_busy_o,
    output logic       illegal_o
);

    localparam int MW = $clog2(MUL_LATENCY + 1);
    localparam logic [MW-1:0] MUL_LOAD   = MW'(MUL_LATENCY - 1);
    localparam logic [2:0]    FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t state_q, state_d;
    logic   take_q, take_d;
    logic   mul_load, flush_load;
    logic   mul_done, flush_done;
    logic   legal, is_mul, accept;

    assign legal  = is_legal(opcode_i, alu_control_i);
    assign is_mul = (opcode_i == OP_RTYPE) && (alu_control_i == FN_MUL);
    assign accept = in_valid_i & in_ready_o;

    ex_cycle_timer #(.W(MW)) u_mul_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (mul_load),
        .load_val_i (MUL_LOAD),
        .dec_i      (state_q == MUL),
        .done_o     (mul_done)
    );

    ex_cycle_timer #(.W(3)) u_flush_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (flush_load),
        .load_val_i (FLUSH_LOAD),
        .dec_i      (state_q == FLUSH),
        .done_o     (flush_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            take_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            take_q  <= take_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        take_d     = take_q;
        mul_load   = 1'b0;
        flush_load = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && out_ready_i && take_q) begin
                    state_d    = FLUSH;
                    flush_load = 1'b1;
                    take_d     = 1'b0;
                end else if (accept) begin
                    if (!legal) begin
                        state_d = IDLE;
                    end else if (is_mul) begin
                        state_d  = MUL;
                        mul_load = 1'b1;
                        take_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                        take_d  = (opcode_i == OP_BEQ) & branch_taken_i;
                    end
                end else if (state_q == DONE && out_ready_i) begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d = DONE;
                end
            end
            FLUSH: begin
                if (flush_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated with rst_n so they read 0 the instant reset asserts,
    // even though the state register only holds IDLE.
    always_comb begin
        in_ready_o  = rst_n & ((state_q == IDLE) |
                               ((state_q == DONE) & out_ready_i & ~take_q));
        ex_latch_o  = rst_n & ((accept & legal & ~is_mul) | ((state_q == MUL) & mul_done));
        out_valid_o = rst_n & (state_q == DONE);
        flush_o     = rst_n & (state_q == FLUSH);
        mul_busy_o  = rst_n & (state_q == MUL);
        illegal_o   = rst_n & accept & ~legal;
    end

endmodule

// File: tb/tb_ex_issue_ctrl.sv
module tb_ex_issue_ctrl;

    localparam int MUL_LATENCY  = 4;
    localparam int FLUSH_CYCLES = 2;

    typedef struct packed {
        logic       iv;
        logic [5:0] op;
        logic [5:0] fn;
        logic       bt;
        logic       ordy;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] alu_control = '0;
    logic       branch_taken = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, ex_latch, out_valid, flush, mul_busy, illegal;
    logic [5:0] obs;
    logic [5:0] exp;

    int errors = 0;
    int checks = 0;

    // reference model: cycles of multiply left, flush cycles left,
    // result waiting in EX/MEM and whether it is a taken branch
    int m_mul_left;
    int m_flush_left;
    bit m_res;
    bit m_take;

    ex_issue_ctrl #(.MUL_LATENCY(MUL_LATENCY), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .opcode_i       (opcode),
        .alu_control_i  (alu_control),
        .branch_taken_i (branch_taken),
        .ex_latch_o     (ex_latch),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .flush_o        (flush),
        .mul_busy_o     (mul_busy),
        .illegal_o      (illegal)
    );

    assign obs = {in_ready, ex_latch, out_valid, flush, mul_busy, illegal};

    always #5 clk = ~clk;

    function automatic stim_t mk(input int iv, input int op, input int fn, input int bt, input int ordy);
        stim_t s;
        s.iv = iv[0]; s.op = op[5:0]; s.fn = fn[5:0]; s.bt = bt[0]; s.ordy = ordy[0];
        return s;
    endfunction

    function automatic bit ref_legal(input int op, input int fn);
        return (op == 0 && fn >= 1 && fn <= 4) || op == 1 || op == 2 || op == 3 || op == 8;
    endfunction

    task automatic model_reset();
        m_mul_left = 0; m_flush_left = 0; m_res = 0; m_take = 0;
    endtask

    task automatic apply(input stim_t s);
        in_valid = s.iv; opcode = s.op; alu_control = s.fn;
        branch_taken = s.bt; out_ready = s.ordy;
        #1;
    endtask

    // expected outputs for the current inputs, then advance one clock
    task automatic model_cycle(output logic [5:0] e);
        bit busy, fl, rdy, acc, lg, mul;
        busy = (m_mul_left > 0);
        fl   = (m_flush_left > 0);
        rdy  = !busy && !fl && (!m_res || (out_ready && !m_take));
        acc  = in_valid && rdy;
        lg   = ref_legal(int'(opcode), int'(alu_control));
        mul  = acc && lg && opcode == 0 && alu_control == 3;
        e = {rdy, (acc && lg && !mul) || (m_mul_left == 1), m_res, fl, busy, acc && !lg};
        if (m_flush_left > 0) m_flush_left--;
        if (m_res && out_ready) begin
            m_res = 0;
            if (m_take) begin
                m_flush_left = FLUSH_CYCLES;
                m_take = 0;
            end
        end
        if (m_mul_left > 0) begin
            m_mul_left--;
            if (m_mul_left == 0) begin
                m_res = 1;
                m_take = 0;
            end
        end
        if (mul) m_mul_left = MUL_LATENCY - 1;
        else if (acc && lg) begin
            m_res = 1;
            m_take = (opcode == 3) && branch_taken;
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        apply(mk(1, 1, 0, 0, 1));
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d obs=%b exp=%b", i, obs, 6'b0);
            end
            @(negedge clk); #1;
        end
        rst_n = 1;
        model_reset();
        apply(mk(0, 1, 0, 0, 1));
        for (int i = 0; i < 2; i++) begin
            model_cycle(exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_release cyc%0d obs=%b exp=%b", i, obs, exp);
            end
            @(negedge clk); apply(mk(0, 1, 0, 0, 1));
        end
    endtask

    task automatic test_add();
        stim_t q[$];
        q.push_back(mk(1, 0, 1, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 1));
        foreach (q[i]) begin
            apply(q[i]);
            model_cycle(exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL add cyc%0d obs=%b exp=%b", i, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mul();
        stim_t q[$];
        int first_ov;
        first_ov = -1;
        q.push_back(mk(1, 0, 3, 0, 0));
        for (int i = 0; i < 4; i++) q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 1));
        foreach (q[i]) begin
            apply(q[i]);
            if (out_valid === 1'b1 && first_ov < 0) first_ov = i;
            model_cycle(exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mul cyc%0d obs=%b exp=%b", i, obs, exp);
            end
            @(negedge clk);
        end
        checks++;
        if (first_ov !== MUL_LATENCY) begin
            errors++;
            $display("FAIL mul_latency got=%0d exp=%0d", first_ov, MUL_LATENCY);
        end
    endtask

    task automatic test_branch(input int taken);
        stim_t q[$];
        int nflush;
        nflush = 0;
        q.push_back(mk(1, 3, 0, taken, 1));
        q.push_back(mk(0, 0, 0, 1, 1));
        for (int i = 0; i < 3; i++) q.push_back(mk(1, 2, 0, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 1));
        foreach (q[i]) begin
            apply(q[i]);
            if (flush === 1'b1) nflush++;
            model_cycle(exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL branch%0d cyc%0d obs=%b exp=%b", taken, i, obs, exp);
            end
            @(negedge clk);
        end
        checks++;
        if (nflush !== (taken != 0 ? FLUSH_CYCLES : 0)) begin
            errors++;
            $display("FAIL branch%0d_flush_len got=%0d exp=%0d", taken, nflush,
                     (taken != 0 ? FLUSH_CYCLES : 0));
        end
    endtask

    task automatic test_back_to_back();
        stim_t q[$];
        int nlatch;
        nlatch = 0;
        q.push_back(mk(1, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) q.push_back(mk(1, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 1));
        foreach (q[i]) begin
            apply(q[i]);
            if (ex_latch === 1'b1) nlatch++;
            model_cycle(exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back cyc%0d obs=%b exp=%b", i, obs, exp);
            end
            @(negedge clk);
        end
        checks++;
        if (nlatch !== 2) begin
            errors++;
            $display("FAIL back_to_back_latches got=%0d exp=%0d", nlatch, 2);
        end
    endtask

    task automatic test_illegal();
        stim_t q[$];
        q.push_back(mk(1, 5, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 1));
        q.push_back(mk(1, 2, 0, 0, 0));
        q.push_back(mk(1, 0, 7, 0, 1));
        q.push_back(mk(1, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 1));
        foreach (q[i]) begin
            apply(q[i]);
            model_cycle(exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL illegal cyc%0d obs=%b exp=%b", i, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        apply(mk(1, 0, 3, 0, 1));
        for (int i = 0; i < 2; i++) begin
            model_cycle(exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL areset_pre cyc%0d obs=%b exp=%b", i, obs, exp);
            end
            @(negedge clk); apply(mk(0, 0, 0, 0, 1));
        end
        #1 rst_n = 0;
        #1;
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL areset_now obs=%b exp=%b", obs, 6'b0);
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 2 * MUL_LATENCY; i++) begin
            apply(mk(0, 0, 0, 0, 1));
            model_cycle(exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL areset_post cyc%0d obs=%b exp=%b", i, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int ops[7];
        ops = '{0, 0, 1, 2, 3, 8, 5};
        for (int i = 0; i < 600; i++) begin
            int op;
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 19) == 0) op = $urandom_range(0, 63);
            apply(mk($urandom_range(0, 3) != 0, op, $urandom_range(0, 5),
                     $urandom_range(0, 1), $urandom_range(0, 2) != 0));
            model_cycle(exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cyc%0d op=%0d fn=%0d obs=%b exp=%b", i, opcode, alu_control, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_add();
        test_mul();
        test_branch(1);
        test_branch(0);
        test_back_to_back();
        test_illegal();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
